// File: rtl/cache_repl_pkg.sv
// cache_repl_pkg: shared FSM states and index-width helpers for the replacement controller
package cache_repl_pkg;
  typedef enum logic {IDLE, FLUSH} state_t;
  localparam int DEF_WAYS = 4;
  localparam int DEF_SETS = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int WAY_W = idx_w(DEF_WAYS);
  localparam int SET_W = idx_w(DEF_SETS);
endpackage

// File: rtl/plru_tree.sv
// plru_tree: tree-PLRU victim walk and touch update for one set (heap-ordered nodes)
module plru_tree
  import cache_repl_pkg::*;
#(
  parameter int NUM_WAYS = DEF_WAYS,
  localparam int WW = idx_w(NUM_WAYS)
) (
  input  logic [NUM_WAYS-2:0] bits,
  input  logic [WW-1:0]       touch_way,
  output logic [WW-1:0]       victim,
  output logic [NUM_WAYS-2:0] bits_nxt
);
  always_comb begin
    int n;
    victim = '0;
    bits_nxt = bits;
    n = 0;
    for (int l = WW - 1; l >= 0; l--) begin
      victim[l] = bits[n];
      n = 2 * n + 1 + int'(bits[n]);
    end
    n = 0;
    // each node on the path now points away from the touched way
    for (int l = WW - 1; l >= 0; l--) begin
      bits_nxt[n] = ~touch_way[l];
      n = 2 * n + 1 + int'(touch_way[l]);
    end
  end
endmodule

// File: rtl/way_replace_ctrl.sv
// way_replace_ctrl: per-set valid tracking, tree-PLRU victim selection and sequential flush
module way_replace_ctrl
  import cache_repl_pkg::*;
#(
  parameter int NUM_WAYS = DEF_WAYS,
  parameter int NUM_SETS = DEF_SETS,
  localparam int WW = idx_w(NUM_WAYS),
  localparam int SW = idx_w(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW-1:0]       set_idx,
  input  logic                hit,
  input  logic [WW-1:0]       hit_way,
  input  logic                alloc_req,
  input  logic                flush_req,
  output logic [WW-1:0]       victim_way,
  output logic                victim_valid,
  output logic [NUM_WAYS-1:0] valid_load,
  output logic                ready,
  output logic                flush_done
);
  state_t state, state_nxt;
  logic [SW-1:0] cnt;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0] plru;
  logic [NUM_WAYS-1:0] set_valid;
  logic [WW-1:0] tree_victim, touch_way;
  logic [NUM_WAYS-2:0] plru_nxt;
  assign set_valid = valid[set_idx];
  assign ready = state == IDLE;
  assign flush_done = state == FLUSH && cnt == SW'(NUM_SETS - 1);
  assign victim_valid = &set_valid;
  assign touch_way = alloc_req ? victim_way : hit_way;
  assign valid_load = (alloc_req && ready) ? {{(NUM_WAYS-1){1'b0}}, 1'b1} << victim_way : '0;
  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_tree (
    .bits(plru[set_idx]),
    .touch_way(touch_way),
    .victim(tree_victim),
    .bits_nxt(plru_nxt)
  );
  // an empty way always wins over the PLRU choice, lowest index first
  always_comb begin
    victim_way = tree_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!set_valid[w]) victim_way = WW'(w);
  end
  always_comb begin
    state_nxt = (state == IDLE) ? (flush_req ? FLUSH : IDLE) : (flush_done ? IDLE : FLUSH);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      valid <= '0;
      plru <= '0;
    end else begin
      state <= state_nxt;
      if (state == FLUSH) begin
        valid[cnt] <= '0;
        plru[cnt] <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        if (flush_req) cnt <= '0;
        if (alloc_req) begin
          valid[set_idx][victim_way] <= 1'b1;
          plru[set_idx] <= plru_nxt;
        end else if (hit) begin
          plru[set_idx] <= plru_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_way_replace_ctrl.sv
// tb_way_replace_ctrl: scoreboard bench driving a 4-way and a 2-way instance against a range-based PLRU model
module tb_way_replace_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, hit, alloc_req, flush_req;
  logic [2:0] set_idx;
  logic [1:0] hit_way;
  logic [1:0] victim_way4;
  logic victim_valid4, ready4, flush_done4;
  logic [3:0] valid_load4;
  logic [0:0] victim_way2;
  logic victim_valid2, ready2, flush_done2;
  logic [1:0] valid_load2;
  typedef struct packed {
    logic [1:0] vw;
    logic       vv;
    logic [3:0] vl;
    logic       rdy;
    logic       fd;
  } exp_t;
  exp_t q4[$], q2[$];
  exp_t me, ma;
  int vectors = 0, errors = 0;
  bit mval[2][8][4];
  bit mbit[2][8][3];
  bit busy[2];
  int fcnt[2];
  way_replace_ctrl #(.NUM_WAYS(4), .NUM_SETS(8)) dut4 (
    .clk(clk), .rst(rst), .set_idx(set_idx), .hit(hit), .hit_way(hit_way),
    .alloc_req(alloc_req), .flush_req(flush_req), .victim_way(victim_way4),
    .victim_valid(victim_valid4), .valid_load(valid_load4), .ready(ready4),
    .flush_done(flush_done4)
  );
  way_replace_ctrl #(.NUM_WAYS(2), .NUM_SETS(8)) dut2 (
    .clk(clk), .rst(rst), .set_idx(set_idx), .hit(hit), .hit_way(hit_way[0:0]),
    .alloc_req(alloc_req), .flush_req(flush_req), .victim_way(victim_way2),
    .victim_valid(victim_valid2), .valid_load(valid_load2), .ready(ready2),
    .flush_done(flush_done2)
  );
  function automatic int pick(int d, int s, int nw);
    int lo = 0, size = nw, node = 0;
    for (int w = 0; w < nw; w++) if (!mval[d][s][w]) return w;
    while (size > 1) begin
      size /= 2;
      if (mbit[d][s][node]) begin lo += size; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction
  task automatic touch(int d, int s, int w, int nw);
    int lo = 0, size = nw, node = 0;
    bit upper;
    while (size > 1) begin
      size /= 2;
      upper = w >= lo + size;
      mbit[d][s][node] = !upper;
      if (upper) begin lo += size; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
  endtask
  task automatic model_step(input int d, input int nw, output exp_t e);
    int s = int'(set_idx);
    int vw = pick(d, s, nw);
    bit full = 1'b1;
    for (int w = 0; w < nw; w++) full &= mval[d][s][w];
    e.vw = 2'(vw);
    e.vv = full;
    e.rdy = !busy[d];
    e.fd = busy[d] && fcnt[d] == 7;
    e.vl = (alloc_req && !busy[d]) ? 4'(1 << vw) : 4'd0;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        for (int w = 0; w < 4; w++) mval[d][i][w] = 1'b0;
        for (int n = 0; n < 3; n++) mbit[d][i][n] = 1'b0;
      end
      busy[d] = 1'b0;
      fcnt[d] = 0;
    end else if (busy[d]) begin
      for (int w = 0; w < 4; w++) mval[d][fcnt[d]][w] = 1'b0;
      for (int n = 0; n < 3; n++) mbit[d][fcnt[d]][n] = 1'b0;
      if (fcnt[d] == 7) busy[d] = 1'b0;
      fcnt[d] = (fcnt[d] + 1) % 8;
    end else begin
      if (alloc_req) begin
        mval[d][s][vw] = 1'b1;
        touch(d, s, vw, nw);
      end else if (hit) begin
        touch(d, s, int'(hit_way) % nw, nw);
      end
      if (flush_req) begin
        busy[d] = 1'b1;
        fcnt[d] = 0;
      end
    end
  endtask
  task automatic cyc(bit r, bit a, bit h, bit f, int s, int hw);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; alloc_req = a; hit = h; flush_req = f;
    set_idx = 3'(s); hit_way = 2'(hw);
    model_step(0, 4, e);
    q4.push_back(e);
    model_step(1, 2, e);
    q2.push_back(e);
  endtask
  always @(negedge clk) begin
    if (q4.size() > 0) begin
      me = q4.pop_front();
      ma = {victim_way4, victim_valid4, valid_load4, ready4, flush_done4};
      vectors++;
      if (ma !== me) begin
        errors++;
        $display("FAIL dut4 t=%0t got vw=%0d vv=%0b vl=%b rdy=%0b fd=%0b want vw=%0d vv=%0b vl=%b rdy=%0b fd=%0b",
                 $time, ma.vw, ma.vv, ma.vl, ma.rdy, ma.fd, me.vw, me.vv, me.vl, me.rdy, me.fd);
      end
    end
    if (q2.size() > 0) begin
      me = q2.pop_front();
      ma = {1'b0, victim_way2, victim_valid2, 2'b00, valid_load2, ready2, flush_done2};
      vectors++;
      if (ma !== me) begin
        errors++;
        $display("FAIL dut2 t=%0t got vw=%0d vv=%0b vl=%b rdy=%0b fd=%0b want vw=%0d vv=%0b vl=%b rdy=%0b fd=%0b",
                 $time, ma.vw, ma.vv, ma.vl, ma.rdy, ma.fd, me.vw, me.vv, me.vl, me.rdy, me.fd);
      end
    end
  end
  initial begin
    rst = 1'b1; hit = 1'b0; alloc_req = 1'b0; flush_req = 1'b0;
    set_idx = '0; hit_way = '0;
    repeat (2) @(posedge clk);
    cyc(0, 0, 0, 0, 3, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 3, 0);
    cyc(0, 0, 0, 0, 3, 0);
    cyc(0, 0, 1, 0, 3, 0);
    cyc(0, 0, 0, 0, 3, 0);
    cyc(0, 1, 1, 0, 3, 2);
    cyc(0, 0, 0, 0, 3, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, i, 1);
    for (int s = 0; s < 8; s++) cyc(0, 0, 0, 0, s, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, i % 3, 0);
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int s = 0; s < 8; s++) cyc(0, 0, 0, 0, s, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0,
          int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    cyc(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
